// File: rtl/window_gen_l2.sv
// window_gen_l2: 3x3 sliding window generator over a raster-order FxF feature map
module window_gen_l2 #(
    parameter int F = 14,
    parameter int B = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [B-1:0]   i_pixel_data,
    input  logic           i_pixel_valid,
    output logic           o_pixel_ready,
    output logic [9*B-1:0] o_window_data,
    output logic           o_window_valid,
    input  logic           i_window_ready,
    output logic           o_frame_done
);
    localparam int CW = $clog2(F);

    typedef enum logic {FILL, RUN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] col, row;
    logic [B-1:0]  line_buf1 [F];
    logic [B-1:0]  line_buf2 [F];
    logic [B-1:0]  win [9];
    logic          accept, consume, col_last, row_last;

    assign o_pixel_ready = !o_window_valid || i_window_ready;
    assign accept        = i_pixel_valid && o_pixel_ready;
    assign consume       = o_window_valid && i_window_ready;
    assign col_last      = col == CW'(F-1);
    assign row_last      = row == CW'(F-1);

    genvar k;
    for (k = 0; k < 9; k++) begin : g_pack
        assign o_window_data[k*B +: B] = win[k];
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= FILL;
        else        state <= state_nx;
    end

    // FILL covers rows 0-1 while the line buffers prime; RUN covers rows that can emit windows
    always_comb begin
        state_nx = state;
        if (accept && col_last) begin
            if (state == FILL && row == CW'(1)) state_nx = RUN;
            else if (state == RUN && row_last)  state_nx = FILL;
        end
    end

    // Raster position counters and end-of-frame pulse
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            col          <= '0;
            row          <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= accept && col_last && row_last;
            if (accept) begin
                col <= col_last ? '0 : col + CW'(1);
                if (col_last) row <= row_last ? '0 : row + CW'(1);
            end
        end
    end

    // Line buffers hold the two previous rows; contents need no reset since FILL hides them
    always_ff @(posedge i_clk) begin
        if (accept) begin
            line_buf2[col] <= line_buf1[col];
            line_buf1[col] <= i_pixel_data;
        end
    end

    // Window shifts left on every accept; accept implies the held window is free or being consumed
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < 9; i++) win[i] <= '0;
            o_window_valid <= 1'b0;
        end else begin
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win[3*r]   <= win[3*r+1];
                    win[3*r+1] <= win[3*r+2];
                end
                win[2] <= line_buf2[col];
                win[5] <= line_buf1[col];
                win[8] <= i_pixel_data;
            end
            if (accept && state == RUN && col >= CW'(2)) o_window_valid <= 1'b1;
            else if (consume)                            o_window_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_window_gen_l2.sv
// tb_window_gen_l2: directed checks of window contents, backpressure, frame pulses and reset
module tb_window_gen_l2;
    localparam int F = 14;
    localparam int B = 8;
    localparam int NW = (F-2)*(F-2);
    localparam logic [71:0] FIRST_WIN = {8'd30, 8'd29, 8'd28, 8'd16, 8'd15, 8'd14, 8'd2, 8'd1, 8'd0};
    localparam logic [71:0] LAST_WIN  = {8'd195, 8'd194, 8'd193, 8'd181, 8'd180, 8'd179, 8'd167, 8'd166, 8'd165};

    logic           clk = 1'b0;
    logic           rst;
    logic [B-1:0]   pixel_data;
    logic           pixel_valid;
    logic           pixel_ready;
    logic [9*B-1:0] window_data;
    logic           window_valid;
    logic           window_ready;
    logic           frame_done;

    logic [71:0] got_q[$];
    int          fd_cnt, fd_long;
    logic        fd_prev = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    window_gen_l2 #(.F(F), .B(B)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_pixel_data   (pixel_data),
        .i_pixel_valid  (pixel_valid),
        .o_pixel_ready  (pixel_ready),
        .o_window_data  (window_data),
        .o_window_valid (window_valid),
        .i_window_ready (window_ready),
        .o_frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    // Record consumed windows and frame-done pulses away from the active edge
    always @(negedge clk) begin
        if (window_valid && window_ready) got_q.push_back(window_data);
        if (frame_done) begin
            fd_cnt++;
            if (fd_prev) fd_long++;
        end
        fd_prev = frame_done;
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] exp_win(input int base, input int w);
        logic [71:0] v;
        int r, c;
        r = w / (F-2);
        c = w % (F-2);
        for (int i = 0; i < 9; i++) v[i*8 +: 8] = 8'((base + (r + i/3)*F + c + i%3) % 256);
        return v;
    endfunction

    task automatic push(input logic [7:0] d, input bit rnd);
        logic acc;
        int   n;
        if (rnd)
            for (int j = 0; j < 4 && $urandom_range(0, 1) == 1; j++) begin
                pixel_valid = 1'b0;
                pixel_data  = 8'($urandom);
                @(posedge clk); #1;
            end
        pixel_data  = d;
        pixel_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = pixel_ready;
            @(posedge clk); #1;
            n++;
        end
        pixel_valid = 1'b0;
        pixel_data  = 8'($urandom);
        if (!acc) begin
            check("accept_timeout", acc, 1);
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $fatal(1, "pixel never accepted");
        end
    endtask

    task automatic send(input int n, input bit rnd);
        for (int i = 0; i < n; i++) push(8'(i % 256), rnd);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic verify(input string tag, input int frames);
        int m;
        check({tag, "_count"}, got_q.size(), NW*frames);
        m = got_q.size() < NW*frames ? got_q.size() : NW*frames;
        for (int i = 0; i < m; i++)
            check($sformatf("%s_win%0d", tag, i), got_q[i], exp_win((i / NW) * F * F, i % NW));
    endtask

    task automatic stall_proc();
        int   n;
        logic [71:0] held;
        n = 0;
        @(negedge clk);
        while (!window_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid", window_valid, 1);
        held = window_data;
        check("stall_first", held, FIRST_WIN);
        repeat (10) begin
            @(negedge clk);
            check("stall_hold", window_data, held);
            check("stall_hold_valid", window_valid, 1);
            check("stall_pixel_ready", pixel_ready, 0);
        end
        @(posedge clk); #1;
        window_ready = 1'b1;
    endtask

    initial begin
        rst          = 1'b1;
        pixel_valid  = 1'b0;
        pixel_data   = '0;
        window_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rst_window_valid", window_valid, 0);
        check("rst_window_data", window_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_pixel_ready", pixel_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b1;
        window_ready = 1'b1;

        got_q.delete(); fd_cnt = 0; fd_long = 0;
        send(F*F, 0);
        verify("cont", 1);
        if (got_q.size() == NW) begin
            check("cont_first", got_q[0], FIRST_WIN);
            check("cont_last", got_q[NW-1], LAST_WIN);
        end
        check("cont_frame_done", fd_cnt, 1);

        got_q.delete(); fd_cnt = 0;
        window_ready = 1'b0;
        fork
            send(F*F, 0);
            stall_proc();
        join
        verify("stall", 1);

        got_q.delete(); fd_cnt = 0;
        send(F*F, 1);
        verify("rand", 1);
        check("rand_frame_done", fd_cnt, 1);

        got_q.delete(); fd_cnt = 0; fd_long = 0;
        send(2*F*F, 0);
        verify("b2b", 2);
        check("b2b_frame_done", fd_cnt, 2);
        check("b2b_pulse_width", fd_long, 0);

        got_q.delete(); fd_cnt = 0;
        for (int i = 0; i < 100; i++) push(8'(i), 0);
        window_ready = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", window_valid, 0);
        check("mid_rst_data", window_data, 0);
        check("mid_rst_pixel_ready", pixel_ready, 1);
        got_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b1;
        window_ready = 1'b1;
        fd_cnt = 0;
        send(F*F, 0);
        verify("after_rst", 1);
        check("after_rst_frame_done", fd_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        check("global_timeout", 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "simulation time limit reached");
    end
endmodule

// File: doc/window_gen_l2.md
WINDOW_GEN_L2 -- requirements
Module: window_gen_l2

Interface
REQ-001 Parameter F, default 14, feature-map width and height in pixels.
REQ-002 Parameter B, default 8, pixel bit width.
REQ-003 i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-low.
REQ-005 i_pixel_data  input  B  one raster-order pixel, row-major, top-left first.
REQ-006 i_pixel_valid  input  1  pixel present on i_pixel_data.
REQ-007 o_pixel_ready  output  1  block accepts a pixel this cycle.
REQ-008 o_window_data  output  9*B  3x3 window; byte k = 3*r+c at bits [k*B +: B]; r=0 is the oldest row, c=0 is the leftmost column.
REQ-009 o_window_valid  output  1  o_window_data holds an unconsumed window.
REQ-010 i_window_ready  input  1  downstream consumes the window this cycle.
REQ-011 o_frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted.

Function
REQ-012 Pixel accept = i_pixel_valid && o_pixel_ready; the block SHALL ignore i_pixel_data on all other cycles.
REQ-013 o_pixel_ready SHALL equal !o_window_valid || i_window_ready (combinational; 1-deep output skid-free register).
REQ-014 Window consume = o_window_valid && i_window_ready; o_window_data and o_window_valid SHALL hold stable while o_window_valid && !i_window_ready.
REQ-015 Column counter col (0..F-1) and row counter row (0..F-1) SHALL advance on each accept; col wraps F-1->0 and increments row; row wraps F-1->0 at frame end.
REQ-016 Storage SHALL be two line buffers of F x B (rows row-2, row-1) plus a 3x3 shift window; on accept, each window row shifts left by one column and takes the new column {line_buf2[col], line_buf1[col], pixel}.
REQ-017 On accept, line_buf2[col] <= line_buf1[col] and line_buf1[col] <= pixel.
REQ-018 State machine: FILL (row<2) and RUN (row>=2); FILL->RUN on accept with col=F-1, row=1; RUN->FILL on accept with col=F-1, row=F-1.
REQ-019 An accept in RUN with col>=2 SHALL set o_window_valid=1 on the next edge, window containing the just-accepted pixel at byte 8; latency exactly 1 cycle.
REQ-020 An accept that produces no window SHALL clear o_window_valid if the current window is consumed in the same cycle, else leave it unchanged.
REQ-021 Simultaneous consume and window-producing accept SHALL load the new window with o_window_valid remaining 1 (no bubble).
REQ-022 Exactly (F-2)*(F-2) windows per frame (144 at F=14); no windows span a row or frame boundary.
REQ-023 o_frame_done SHALL assert for one cycle on the edge after the accept at row=F-1, col=F-1.
REQ-024 Line-buffer contents are don't-care at frame start; the FILL phase SHALL guarantee no stale data reaches a valid window.

Reset
REQ-025 On i_rst=0: col=0, row=0, state=FILL, o_window_valid=0, o_window_data=0, o_frame_done=0, immediately and asynchronously.
REQ-026 o_pixel_ready SHALL read 1 during and after reset (follows REQ-013).
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; the next accepted pixel is treated as (row 0, col 0).
REQ-028 Line-buffer RAM need not be reset.

Verification
REQ-029 Feed 196 pixels value = index mod 256, i_window_ready=1 continuous -> 144 windows; first window bytes 0..8 = {0,1,2,14,15,16,28,29,30}; last = {165,166,167,179,180,181,193,194,195}.
REQ-030 Same frame, i_window_ready held 0 after first window -> o_pixel_ready=0, window stable for 10 cycles; release -> stream resumes, no window lost or duplicated.
REQ-031 i_pixel_valid toggled randomly 50% -> window sequence identical to REQ-029.
REQ-032 Two back-to-back frames -> o_frame_done pulses twice, exactly 1 cycle each; second frame windows match REQ-029 with values offset by 196 mod 256.
REQ-033 Reset asserted at pixel 100 then full frame sent -> 144 windows matching REQ-029, no window from the aborted frame after reset.
REQ-034 Count rule: no o_window_valid rising during rows 0-1 or at cols 0-1 of any row.
